// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over valid/ready, assembles little-endian
// 32-bit words and writes them into the instruction memory starting at BASE_ADDR.
// The core is held in reset (cpu_hold) while a load is in progress.
// Stream format: 4-byte length N, then N little-endian payload words.
// Optional feature macro: IMEM_LOADER_CKSUM_EN appends a 4-byte trailer that must
// equal the modulo-2^32 sum of all payload words.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        s_ready_q, ready_d;
  logic        mem_rw_q;
  logic        busy_q, busy_d;
  logic        done_q, error_q;
  logic [31:0] word_count_q;
  logic [31:0] mem_address_q, mem_data_in_q;
  logic [1:0]  byte_q;
  logic [23:0] asm_q;
  logic [31:0] idx_q;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] sum_q;
`endif

  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;

  assign accept    = s_valid && s_ready_q;
  assign last_byte = accept && (byte_q == 2'd3);
  // The 4th byte is taken straight from the stream so the full word is
  // available on the accepting edge without an extra cycle.
  assign word_full = {s_data, asm_q};

  // Next-state decode plus the output values the next state will present.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        if (last_byte) begin
          if (word_full == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_DONE;
`endif
          end else if (word_full > 32'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q + 32'd1 == word_count_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (last_byte) state_d = (word_full == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LEN, S_DATA: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_WRITE: busy_d = 1'b1;
      default: ;
    endcase
  end

  // State register, registered outputs and datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      s_ready_q     <= 1'b0;
      mem_rw_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      word_count_q  <= '0;
      mem_address_q <= BASE_ADDR;
      mem_data_in_q <= '0;
      byte_q        <= '0;
      asm_q         <= '0;
      idx_q         <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q   <= state_d;
      s_ready_q <= ready_d;
      busy_q    <= busy_d;
      mem_rw_q  <= (state_d == S_WRITE);
      done_q    <= (state_d == S_DONE);
      error_q   <= (state_d == S_ERROR);

      if (accept) begin
        byte_q <= byte_q + 2'd1;
        case (byte_q)
          2'd0:    asm_q[7:0]   <= s_data;
          2'd1:    asm_q[15:8]  <= s_data;
          2'd2:    asm_q[23:16] <= s_data;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            byte_q <= '0;
            idx_q  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
        S_LEN: begin
          if (last_byte) word_count_q <= word_full;
        end
        S_DATA: begin
          if (last_byte) begin
            mem_data_in_q <= word_full;
            mem_address_q <= BASE_ADDR + (idx_q << 2);
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q         <= sum_q + word_full;
`endif
          end
        end
        S_WRITE: idx_q <= idx_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign mem_address    = mem_address_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_read_write = mem_rw_q;
  assign busy           = busy_q;
  assign cpu_hold       = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a stream-level reference model predicts every
// output on every cycle from the bytes accepted so far; directed cases pin the
// model with literal expectations, then randomized loads stress handshakes.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          MAXW = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_read_write, busy, cpu_hold, done, error;
  logic [31:0] mem_address, mem_data_in, word_count;

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_write(mem_read_write), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .error(error), .word_count(word_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mv = 0;          // model synchronised by a reset
  bit          loading = 0;     // a start has been taken since reset
  bit          strobe_now = 0;  // this cycle is the write cycle of a word
  logic [7:0]  got[$];          // bytes accepted since the last start
  logic [31:0] last_addr = BASE, last_data = '0, wc = '0, sum = '0;
  bit          p_rst, p_start, p_acc;
  logic [7:0]  p_byte;
  logic [31:0] wa[$], wd[$];    // observed write strobes

  function automatic logic [31:0] nlen();
    return {got[3], got[2], got[1], got[0]};
  endfunction
  function automatic bit bad_len();
    return got.size() >= 4 && nlen() > MAXW;
  endfunction
  function automatic longint total();
    longint t = 4 + 4 * longint'(nlen());
`ifdef IMEM_LOADER_CKSUM_EN
    t += 4;
`endif
    return t;
  endfunction
  function automatic bit fin_e();
    if (!loading || got.size() < 4) return 0;
    if (bad_len()) return 1;
    return longint'(got.size()) >= total() && !strobe_now;
  endfunction
  function automatic bit busy_e();
    return loading && !fin_e();
  endfunction
  function automatic bit ready_e();
    return busy_e() && !strobe_now && (got.size() < 4 || longint'(got.size()) < total());
  endfunction
  function automatic bit cks_ok();
`ifdef IMEM_LOADER_CKSUM_EN
    int n = got.size();
    return {got[n-1], got[n-2], got[n-3], got[n-4]} == sum;
`else
    return 1;
`endif
  endfunction
  function automatic bit done_e();
    return fin_e() && !bad_len() && cks_ok();
  endfunction

  task automatic push(input logic [7:0] b);
    int n;
    logic [31:0] w;
    got.push_back(b);
    n = got.size();
    strobe_now = 0;
    if (n == 4) wc = nlen();
    else if (n > 4 && n % 4 == 0 && !bad_len() && longint'(n) <= 4 + 4 * longint'(nlen())) begin
      w = {got[n-1], got[n-2], got[n-3], got[n-4]};
      strobe_now = 1;
      last_addr  = BASE + 32'(n / 4 - 2) * 32'd4;
      last_data  = w;
      sum        = sum + w;
    end
  endtask

  // Model update for the edge just passed, then compare, then sample inputs.
  always @(negedge clock) begin
    bit b;
    if (p_rst) begin
      mv = 1; loading = 0; strobe_now = 0; got.delete();
      last_addr = BASE; last_data = '0; wc = '0; sum = '0;
    end else if (mv) begin
      b = busy_e();
      if (p_start && !b) begin
        got.delete(); loading = 1; sum = '0; strobe_now = 0;
      end else if (p_acc) push(p_byte);
      else strobe_now = 0;
    end
    if (mv) begin
      chk("s_ready", 32'(s_ready), 32'(ready_e()));
      chk("mem_read_write", 32'(mem_read_write), 32'(strobe_now));
      chk("busy", 32'(busy), 32'(busy_e()));
      chk("cpu_hold", 32'(cpu_hold), 32'(busy_e()));
      chk("done", 32'(done), 32'(done_e()));
      chk("error", 32'(error), 32'(fin_e() && !done_e()));
      chk("word_count", word_count, wc);
      chk("mem_address", mem_address, last_addr);
      chk("mem_data_in", mem_data_in, last_data);
      if (mem_read_write === 1'b1) begin
        wa.push_back(mem_address);
        wd.push_back(mem_data_in);
      end
    end
    p_rst   = reset;
    p_start = start;
    p_acc   = mv && s_valid && ready_e();
    p_byte  = s_data;
  end

  // ---------------- stimulus ----------------
  logic [7:0]  stream[$];
  logic [31:0] img[$];

  task automatic build(input logic [31:0] n, input int ck);
    logic [31:0] s = '0;
    stream.delete();
    for (int unsigned i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
    foreach (img[j]) begin
      s = s + img[j];
      for (int unsigned i = 0; i < 4; i++) stream.push_back(img[j][8*i +: 8]);
    end
`ifdef IMEM_LOADER_CKSUM_EN
    if (ck == 2) s = s + 32'd1;
    if (ck != 0) for (int unsigned i = 0; i < 4; i++) stream.push_back(s[8*i +: 8]);
`endif
  endtask

  // Present one byte after 'gap' idle cycles; returns on the accepting edge (+1).
  task automatic drive_byte(input logic [7:0] b, input int gap, input bit with_start);
    int budget = 0;
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0; s_data = 8'($urandom);
      @(posedge clock); #1;
    end
    s_valid = 1'b1; s_data = b; start = with_start;
    forever begin
      @(negedge clock);
      if (s_ready === 1'b1) begin
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
      start = 1'b0;
      budget++;
      if (budget > 50) begin
        errors++;
        $display("FAIL handshake_timeout: byte %h not accepted within 50 cycles", b);
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap_pct, input int start_pct);
    foreach (stream[i])
      drive_byte(stream[i], ($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0,
                 $urandom_range(0, 99) < start_pct);
  endtask

  task automatic pulse_start();
    wa.delete(); wd.delete();
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin @(posedge clock); #1; n++; end
    if (n >= 40) begin
      errors++;
      $display("FAIL idle_timeout: busy still high after 40 cycles");
    end
    @(posedge clock); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_rw"}, 32'(mem_read_write), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_wc"}, word_count, 32'd0);
    chk({tag, "_addr"}, mem_address, 32'h0100_0000);
    chk({tag, "_data"}, mem_data_in, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_vals("rst");

    // two-word image, s_valid continuously high
    pulse_start();
    img = '{32'h13, 32'h6F}; build(2, 1); send_stream(0, 0); wait_idle();
    chk("t1_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() >= 2) begin
      chk("t1_a0", wa[0], 32'h0100_0000); chk("t1_d0", wd[0], 32'h0000_0013);
      chk("t1_a1", wa[1], 32'h0100_0004); chk("t1_d1", wd[1], 32'h0000_006F);
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_wc", word_count, 32'd2);
    chk("t1_hold", 32'(cpu_hold), 32'd0);

    // zero-length image
    pulse_start();
    img = {}; build(0, 1); send_stream(0, 0); wait_idle();
    chk("t2_nwr", 32'(wa.size()), 32'd0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_wc", word_count, 32'd0);

    // oversized length
    pulse_start();
    img = {}; build(32'h401, 0); send_stream(0, 0); wait_idle();
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_nwr", 32'(wa.size()), 32'd0);
    chk("t3_ready", 32'(s_ready), 32'd0);

    // stalls between bytes and an ignored start mid-load
    pulse_start();
    img = '{32'hDEAD_BEEF}; build(1, 1);
    foreach (stream[i]) drive_byte(stream[i], (i >= 4) ? 2 : 0, i == 5);
    wait_idle();
    chk("t4_nwr", 32'(wa.size()), 32'd1);
    if (wa.size() >= 1) begin
      chk("t4_a0", wa[0], 32'h0100_0000); chk("t4_d0", wd[0], 32'hDEAD_BEEF);
    end
    chk("t4_done", 32'(done), 32'd1);

    // reset after two payload bytes, then a clean reload
    pulse_start();
    img = '{32'h1122_3344, 32'h5566_7788}; build(2, 1);
    for (int i = 0; i < 6; i++) drive_byte(stream[i], 0, 0);
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    check_reset_vals("t5");
    chk("t5_nwr", 32'(wa.size()), 32'd0);
    pulse_start();
    img = '{32'hCAFE_F00D}; build(1, 1); send_stream(30, 0); wait_idle();
    chk("t5_nwr2", 32'(wa.size()), 32'd1);
    if (wa.size() >= 1) chk("t5_d0", wd[0], 32'hCAFE_F00D);

`ifdef IMEM_LOADER_CKSUM_EN
    pulse_start();
    img = '{32'h13, 32'h6F}; build(2, 1); send_stream(0, 0); wait_idle();
    chk("ck_good_done", 32'(done), 32'd1);
    chk("ck_good_trailer", {stream[11], stream[10], stream[9], stream[8]}, 32'h82);
    pulse_start();
    build(2, 2); send_stream(0, 0); wait_idle();
    chk("ck_bad_error", 32'(error), 32'd1);
    chk("ck_bad_done", 32'(done), 32'd0);
    chk("ck_bad_nwr", 32'(wa.size()), 32'd2);
`endif

    // randomized loads with stalls and spurious starts
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 8);
      img = {};
      for (int j = 0; j < n; j++) img.push_back($urandom);
      pulse_start();
      build(32'(n), 1 + int'($urandom_range(0, 1)));
      send_stream(40, 10); wait_idle();
      chk("rnd_nwr", 32'(wa.size()), 32'(n));
    end

    // largest accepted image
    img = {};
    for (int j = 0; j < MAXW; j++) img.push_back($urandom);
    pulse_start();
    build(32'(MAXW), 1); send_stream(0, 0); wait_idle();
    chk("max_nwr", 32'(wa.size()), 32'(MAXW));
    chk("max_done", 32'(done), 32'd1);
    if (wa.size() == MAXW) chk("max_last_addr", wa[MAXW-1], 32'h0100_0FFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
